// File: rtl/nimplus_dac_pkg.sv
// Shared DAC programming-interface definitions.
// Frame layout, command codes and small helpers for the NIM+ DAC path.
package nimplus_dac_pkg;

  localparam int DAC_FRAME_BITS = 24;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] ADDR_ALL         = 4'hF;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [3:0]  pad;
  } dac_frame_t;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN,
    ST_CHECK
  } mon_state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage input synchroniser with edge flags.
// Edges compare the last stage with one further registered copy.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = q & ~r_prev;
  assign fall = ~q & r_prev;

endmodule

// File: rtl/dac_serial_monitor.sv
// Passive DAC serial-bus monitor: deserialises frames off the
// SCLK/NSYNC/DIN taps and keeps shadow copies of programmed codes.
module dac_serial_monitor
  import nimplus_dac_pkg::*;
#(
  parameter int FRAME_BITS  = DAC_FRAME_BITS,
  parameter int N_CH        = 8,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dac_sclk,
  input  logic                      dac_nsync,
  input  logic                      dac_din,
  output logic                      frame_valid,
  output logic [FRAME_BITS-1:0]     frame_word,
  output logic [3:0]                frame_cmd,
  output logic [3:0]                frame_addr,
  output logic [DATA_BITS-1:0]      frame_data,
  output logic                      frame_err,
  output logic [N_CH*DATA_BITS-1:0] shadow,
  output logic [15:0]               frame_count,
  output logic [15:0]               err_count,
  output logic                      busy
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int WW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [WW-1:0] WAIT_MAX = WW'(SYNC_STAGES);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_nsync_q, w_nsync_rise, w_nsync_fall;
  logic w_din_q, w_din_rise, w_din_fall;

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (dac_sclk),
    .q     (w_sclk_q),
    .rise  (w_sclk_rise),
    .fall  (w_sclk_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_nsync (
    .clk   (clk),
    .reset (reset),
    .d     (dac_nsync),
    .q     (w_nsync_q),
    .rise  (w_nsync_rise),
    .fall  (w_nsync_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_din (
    .clk   (clk),
    .reset (reset),
    .d     (dac_din),
    .q     (w_din_q),
    .rise  (w_din_rise),
    .fall  (w_din_fall)
  );

  mon_state_t            r_state, w_next;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [FRAME_BITS-1:0] r_shreg, w_sh_nxt;
  logic                  r_ovr, w_ovr_nxt;
  logic [WW-1:0]         r_wcnt, w_wcnt_nxt;
  logic                  w_good, w_bad;
  dac_frame_t            w_frm;

  logic                      r_valid, r_err;
  logic [FRAME_BITS-1:0]     r_word;
  logic [N_CH*DATA_BITS-1:0] r_shadow;
  logic [15:0]               r_fcnt, r_ecnt;

  assign w_frm = dac_frame_t'(r_shreg[FRAME_BITS-1 -: $bits(dac_frame_t)]);

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_sh_nxt   = r_shreg;
    w_ovr_nxt  = r_ovr;
    w_wcnt_nxt = r_wcnt;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    unique case (r_state)
      // Sync flops reset high, so let them refill with real pin
      // levels before trusting nsync; a frame in flight is dropped.
      ST_WAIT_IDLE: begin
        if (r_wcnt != WAIT_MAX) begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end else if (w_nsync_q) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_nsync_fall) begin
          w_next    = ST_SHIFT;
          w_cnt_nxt = '0;
          w_sh_nxt  = '0;
          w_ovr_nxt = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_nsync_rise) begin
          w_next = ST_CHECK;
        end else if (w_sclk_fall) begin
          if (r_cnt == CNT_FULL) begin
            w_next    = ST_OVERRUN;
            w_ovr_nxt = 1'b1;
          end else begin
            w_sh_nxt  = {r_shreg[FRAME_BITS-2:0], w_din_q};
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_OVERRUN: begin
        if (w_nsync_rise) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_next = ST_IDLE;
        if (r_cnt == CNT_FULL && !r_ovr) begin
          w_good = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_next = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_ovr   <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_sh_nxt;
      r_ovr   <= w_ovr_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_word   <= '0;
      r_shadow <= '0;
      r_fcnt   <= '0;
      r_ecnt   <= '0;
    end else begin
      r_valid <= w_good;
      r_err   <= w_bad;
      if (w_good) begin
        r_word <= r_shreg;
        r_fcnt <= sat_inc(r_fcnt);
        if (w_frm.cmd == CMD_WRITE_UPDATE) begin
          for (int k = 0; k < N_CH; k++) begin
            if (w_frm.addr == ADDR_ALL || w_frm.addr == 4'(k)) begin
              r_shadow[k*DATA_BITS +: DATA_BITS] <=
                DATA_BITS'(w_frm.data);
            end
          end
        end
      end
      if (w_bad) begin
        r_ecnt <= sat_inc(r_ecnt);
      end
    end
  end

  assign frame_valid = r_valid;
  assign frame_err   = r_err;
  assign frame_word  = r_word;
  assign frame_cmd   = r_word[FRAME_BITS-1 -: 4];
  assign frame_addr  = r_word[FRAME_BITS-5 -: 4];
  assign frame_data  = r_word[FRAME_BITS-9 -: DATA_BITS];
  assign shadow      = r_shadow;
  assign frame_count = r_fcnt;
  assign err_count   = r_ecnt;
  assign busy        = (r_state == ST_SHIFT) ||
                       (r_state == ST_OVERRUN);

  logic w_unused;
  assign w_unused = &{1'b0, w_sclk_q, w_sclk_rise,
                      w_din_rise, w_din_fall, w_frm.pad};

endmodule

// File: tb/tb_dac_serial_monitor.sv
// Directed bench for dac_serial_monitor: drives DAC frames at clk/8
// and checks pulses, latency, counters and shadow registers.
module tb_dac_serial_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_sclk;
  logic        dac_nsync;
  logic        dac_din;
  logic        frame_valid;
  logic [23:0] frame_word;
  logic [3:0]  frame_cmd;
  logic [3:0]  frame_addr;
  logic [11:0] frame_data;
  logic        frame_err;
  logic [95:0] shadow;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic        busy;

  int vecs = 0;
  int errs = 0;
  int nv = 0;
  int ne = 0;

  dac_serial_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .dac_sclk    (dac_sclk),
    .dac_nsync   (dac_nsync),
    .dac_din     (dac_din),
    .frame_valid (frame_valid),
    .frame_word  (frame_word),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .shadow      (shadow),
    .frame_count (frame_count),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid) nv++;
    if (frame_err) ne++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input int n,
                      input int rst_at, input int rst_rel,
                      input logic exp_busy,
                      input logic exp_v, input logic exp_e);
    int nv0, ne0;
    nv0 = nv;
    ne0 = ne;
    dac_nsync = 1'b0;
    tick(4);
    for (int b = 0; b < n; b++) begin
      if (b == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_fcnt", frame_count, 0);
        chk("rst_word", frame_word, 0);
        chk("rst_shadow", shadow, 0);
      end
      if (b == rst_rel) reset = 1'b0;
      dac_din  = w[n-1-b];
      dac_sclk = 1'b1;
      tick(4);
      dac_sclk = 1'b0;
      tick(4);
    end
    chk("busy_end", busy, exp_busy);
    dac_nsync = 1'b1;
    dac_din   = 1'b0;
    tick(3);
    chk("pre_pulse", {frame_valid, frame_err}, 2'b00);
    tick(1);
    chk("pulse", {frame_valid, frame_err}, {exp_v, exp_e});
    tick(1);
    chk("post_pulse", {frame_valid, frame_err}, 2'b00);
    tick(6);
    chk("n_valid", nv - nv0, exp_v);
    chk("n_err", ne - ne0, exp_e);
  endtask

  initial begin
    reset     = 1'b1;
    dac_sclk  = 1'b0;
    dac_nsync = 1'b1;
    dac_din   = 1'b0;
    tick(5);
    chk("r_valid", frame_valid, 0);
    chk("r_err", frame_err, 0);
    chk("r_word", frame_word, 0);
    chk("r_shadow", shadow, 0);
    chk("r_fcnt", frame_count, 0);
    chk("r_ecnt", err_count, 0);
    chk("r_busy", busy, 0);
    reset = 1'b0;
    tick(6);

    // good frame to channel 2
    send(32'h0032ABC0, 24, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t1_word", frame_word, 24'h32ABC0);
    chk("t1_cmd", frame_cmd, 4'h3);
    chk("t1_addr", frame_addr, 4'h2);
    chk("t1_data", frame_data, 12'hABC);
    chk("t1_shadow", shadow, 96'h000_000_000_000_000_ABC_000_000);
    chk("t1_fcnt", frame_count, 1);
    chk("t1_ecnt", err_count, 0);
    chk("t1_busy", busy, 0);

    // short frame: 20 bits
    send(32'h00035DEF, 20, -1, -1, 1'b1, 1'b0, 1'b1);
    chk("t2_ecnt", err_count, 1);
    chk("t2_fcnt", frame_count, 1);
    chk("t2_word", frame_word, 24'h32ABC0);
    chk("t2_shadow", shadow, 96'h000_000_000_000_000_ABC_000_000);

    // overrun: 26 falls
    send({6'h0, 24'h311110, 2'b11}, 26, -1, -1, 1'b1, 1'b0, 1'b1);
    chk("t3_ecnt", err_count, 2);
    chk("t3_word", frame_word, 24'h32ABC0);
    chk("t3_shadow", shadow, 96'h000_000_000_000_000_ABC_000_000);

    // broadcast, then two non-updating frames
    send(32'h003F1230, 24, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t4a_shadow", shadow, 96'h123_123_123_123_123_123_123_123);
    chk("t4a_fcnt", frame_count, 2);
    send(32'h00014560, 24, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t4b_word", frame_word, 24'h014560);
    chk("t4b_data", frame_data, 12'h456);
    chk("t4b_shadow", shadow, 96'h123_123_123_123_123_123_123_123);
    send(32'h00397770, 24, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t4c_addr", frame_addr, 4'h9);
    chk("t4c_shadow", shadow, 96'h123_123_123_123_123_123_123_123);
    chk("t4c_fcnt", frame_count, 4);
    chk("t4c_ecnt", err_count, 2);

    // reset during bits 10..13, tail discarded
    send(32'h00345A50, 24, 10, 14, 1'b0, 1'b0, 1'b0);
    chk("t5_fcnt", frame_count, 0);
    chk("t5_ecnt", err_count, 0);
    chk("t5_shadow", shadow, 0);
    send(32'h00360F00, 24, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t5_word", frame_word, 24'h360F00);
    chk("t5_shadow2", shadow, 96'h000_0F0_000_000_000_000_000_000);
    chk("t5_fcnt2", frame_count, 1);

    // controller-style sequence: code 0x100*k to channel k
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    for (int k = 0; k < 8; k++) begin
      send({8'h00, 4'h3, 4'(k), 12'(k * 256), 4'h0}, 24,
           -1, -1, 1'b1, 1'b1, 1'b0);
    end
    chk("t6_shadow", shadow, 96'h700_600_500_400_300_200_100_000);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6_sh%0d", k), shadow[k*12 +: 12], 12'(k * 256));
    end
    chk("t6_fcnt", frame_count, 8);
    chk("t6_ecnt", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dac_serial_monitor.md
Name: dac_serial_monitor

Overview:
- Passive receiver for the DAC programming interface: samples DAC_SER_CLK / DAC_NSYNC / DAC_DIN as driven by the DAC controller and deserialises each frame.
- Exposes decoded frames plus per-channel shadow copies of the last programmed DAC codes, for readback into params_out and for bench self-checking of threshold programming.
- Sits beside the DAC controller in the NIM+ top and taps the same three pins; it never drives them.

Parameters:
- FRAME_BITS, 24, bits per DAC frame, MSB first.
- N_CH, 8, number of DAC channels shadowed.
- DATA_BITS, 12, DAC code width.
- SYNC_STAGES, 2, synchroniser depth on each serial input (minimum 2).

Ports:
- clk  in  1  sampling clock; must be at least 4x the SCLK rate.
- reset  in  1  asynchronous, active-high.
- dac_sclk  in  1  serial clock tap.
- dac_nsync  in  1  frame sync tap, active-low.
- dac_din  in  1  serial data tap.
- frame_valid  out  1  one-cycle pulse when a good frame completes.
- frame_word  out  FRAME_BITS  raw captured word; held until the next good frame.
- frame_cmd  out  4  frame_word[23:20].
- frame_addr  out  4  frame_word[19:16].
- frame_data  out  DATA_BITS  frame_word[15:4].
- frame_err  out  1  one-cycle pulse on a malformed frame.
- shadow  out  N_CH*DATA_BITS  last written code per channel; channel k occupies bits [k*DATA_BITS +: DATA_BITS].
- frame_count  out  16  good frames received, saturating.
- err_count  out  16  error frames received, saturating.
- busy  out  1  high while a frame is being shifted in.

Behaviour:
- All three inputs pass through SYNC_STAGES flip-flops. Edge detection compares the last synchroniser stage with one further registered copy.
- SCLK falling edge = sample event; dac_din is sampled from the synchronised copy in the same cycle.
- FSM states:
  - WAIT_IDLE: entered on reset. Moves to IDLE once synchronised nsync is high, so a frame already in progress when reset releases is discarded.
  - IDLE: nsync falling edge -> SHIFT, with bit counter = 0 and shift register = 0.
  - SHIFT: each sample event shifts din in at the LSB (shreg <= {shreg, din}) and increments the counter. A sample event with counter == FRAME_BITS -> OVERRUN. nsync rising edge -> CHECK.
  - OVERRUN: ignore sample events; nsync rising edge -> CHECK with the overrun flag set.
  - CHECK: one cycle. If counter == FRAME_BITS and no overrun: register frame_word, pulse frame_valid, update shadow, increment frame_count. Otherwise pulse frame_err and increment err_count; frame_word and shadow are untouched. Then -> IDLE.
- Simultaneous sample event and nsync rise in the same cycle: the rise wins and the sample event is ignored.
- Latency: frame_valid / frame_err rise SYNC_STAGES+2 clk cycles after the pin-level NSYNC rising edge (4 cycles at the default).
- Shadow update happens only when cmd == 4'h3 (write-and-update):
  - addr < N_CH: shadow[addr] <= frame_data.
  - addr == 4'hF: all channels <= frame_data.
  - any other addr: no update, but frame_valid still pulses.
- Counters stop at 16'hFFFF and never wrap.
- busy = state in {SHIFT, OVERRUN}.
- Reset values: all outputs 0; state WAIT_IDLE; synchroniser flip-flops reset to 1 for nsync and sclk, 0 for din.
- Reset asserted mid-frame: outputs clear immediately; the remainder of that frame is discarded via WAIT_IDLE.

Decomposition:
- Shared package nimplus_dac_pkg:
  - FRAME_BITS default.
  - Command constants CMD_WRITE_UPDATE = 4'h3 and ADDR_ALL = 4'hF.
  - Typedef dac_frame_t, a packed struct {cmd[3:0], addr[3:0], data[11:0], pad[3:0]}, used by both the DAC controller and this block.
- One natural sub-module: sync_edge_detect, a SYNC_STAGES synchroniser with registered rise/fall outputs. Instantiate it three times.

Test Plan:
1. Good frame: 24-bit frame 0x3_2_ABC_0 at SCLK = clk/8 -> one frame_valid, frame_data = 12'hABC, shadow ch2 = 12'hABC, frame_count = 1, other channels 0.
2. Short frame: nsync rises after 20 bits -> frame_err pulse, err_count = 1, frame_word and shadow unchanged.
3. Overrun: 26 SCLK falls within one NSYNC low -> single frame_err at the NSYNC rise, no shadow change.
4. Broadcast and ignore:
   - 0x3_F_123_0 -> all 8 shadows = 12'h123.
   - Then 0x0_1_456_0 -> frame_valid pulses, shadow unchanged.
   - Then 0x3_9_777_0 -> frame_valid pulses, shadow unchanged.
5. Reset mid-frame: assert reset at bit 10 and release at bit 14 -> no valid and no err for that frame; the next full frame is captured normally.
6. Loopback against the DAC controller: drive it with 8 writes of codes 0x100·k -> shadow matches all 8 codes, frame_count = 8, err_count = 0.
